// File: rtl/clap_pkg.sv
// Shared state encoding and counter sizing for the double-clap detector.
package clap_pkg;

    localparam int unsigned FCNT_WIDTH  = 16;
    localparam int unsigned STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 3'd0,
        ST_PEAK1 = 3'd1,
        ST_GAP   = 3'd2,
        ST_PEAK2 = 3'd3,
        ST_COOL  = 3'd4
    } clap_state_t;

    localparam logic [FCNT_WIDTH-1:0] FCNT_MAX = '1;

endpackage

// File: rtl/track_noise_floor.sv
// Adaptive noise floor: leaky average of quiet frames, 1/16 weight per update.
module track_noise_floor #(
    parameter int unsigned ENERGY_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    update,
    input  logic [ENERGY_WIDTH-1:0] energy_data,
    output logic [ENERGY_WIDTH-1:0] noise_floor
);

    logic [ENERGY_WIDTH-1:0] floor_q;
    logic [ENERGY_WIDTH-1:0] floor_d;

    // floor*15/16 + data/16 can never exceed all-ones, so no saturation needed
    always_comb begin
        floor_d = floor_q;
        if (update) begin
            floor_d = floor_q - (floor_q >> 4) + (energy_data >> 4);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            floor_q <= '0;
        end else begin
            floor_q <= floor_d;
        end
    end

    assign noise_floor = floor_q;

endmodule

// File: rtl/detect_clap.sv
// Double-clap detector toggling a lamp on each valid clap pair.
// Define DETECT_CLAP_NOISE_FLOOR_EN to raise both thresholds by an adaptive noise floor.
module detect_clap
    import clap_pkg::*;
#(
    parameter int unsigned ENERGY_WIDTH = 16,
    parameter int unsigned TH_HIGH      = 1000,
    parameter int unsigned TH_LOW       = 500,
    parameter int unsigned MIN_GAP      = 2,
    parameter int unsigned MAX_GAP      = 20,
    parameter int unsigned MAX_PEAK     = 4,
    parameter int unsigned COOLDOWN     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ENERGY_WIDTH-1:0] energy_data,
    input  logic                    energy_valid,
    output logic                    energy_ready,
    output logic                    light,
    output logic                    event_valid,
    input  logic                    event_ready
);

    // Threshold arithmetic is wide enough to hold any 32-bit parameter plus the floor
    localparam int unsigned SW = (ENERGY_WIDTH > 32) ? ENERGY_WIDTH + 1 : 33;
    localparam int unsigned CW = FCNT_WIDTH + 1;
    localparam logic [SW-1:0] E_MAX = (SW'(1) << ENERGY_WIDTH) - SW'(1);

    clap_state_t             state_q;
    clap_state_t             state_d;
    logic [FCNT_WIDTH-1:0]   fcnt_q;
    logic [FCNT_WIDTH-1:0]   fcnt_d;
    logic                    light_q;
    logic                    light_d;
    logic                    event_q;
    logic                    event_d;

    logic                    accept;
    logic                    hi;
    logic                    lo;
    logic [SW-1:0]           th_high;
    logic [SW-1:0]           th_low;
    logic [CW-1:0]           fcnt_p1;

    assign energy_ready = !event_q;
    assign accept       = energy_valid && !event_q;
    assign fcnt_p1      = CW'(fcnt_q) + CW'(1);

`ifdef DETECT_CLAP_NOISE_FLOOR_EN
    logic [ENERGY_WIDTH-1:0] noise_floor;
    logic [SW-1:0]           th_high_sum;
    logic [SW-1:0]           th_low_sum;

    track_noise_floor #(
        .ENERGY_WIDTH (ENERGY_WIDTH)
    ) u_floor (
        .clock       (clock),
        .reset       (reset),
        .update      (accept && (state_q == ST_IDLE) && !hi),
        .energy_data (energy_data),
        .noise_floor (noise_floor)
    );

    assign th_high_sum = SW'(TH_HIGH) + SW'(noise_floor);
    assign th_low_sum  = SW'(TH_LOW) + SW'(noise_floor);
    assign th_high     = (th_high_sum > E_MAX) ? E_MAX : th_high_sum;
    assign th_low      = (th_low_sum > E_MAX) ? E_MAX : th_low_sum;
`else
    assign th_high = SW'(TH_HIGH);
    assign th_low  = SW'(TH_LOW);
`endif

    assign hi = SW'(energy_data) >= th_high;
    assign lo = SW'(energy_data) < th_low;

    // Next state, frame counter, lamp and event flag
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        light_d = light_q;
        event_d = event_q;

        if (event_q && event_ready) begin
            event_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (hi) state_d = ST_PEAK1;
                end
                ST_PEAK1: begin
                    if (lo)                               state_d = ST_GAP;
                    else if (fcnt_p1 >= CW'(MAX_PEAK))    state_d = ST_COOL;
                end
                ST_GAP: begin
                    if (hi && (fcnt_q >= FCNT_WIDTH'(MIN_GAP))) state_d = ST_PEAK2;
                    else if (hi)                              state_d = ST_COOL;
                    else if (fcnt_p1 >= CW'(MAX_GAP))         state_d = ST_IDLE;
                end
                ST_PEAK2: begin
                    if (lo) begin
                        state_d = ST_COOL;
                        light_d = !light_q;
                        event_d = 1'b1;
                    end else if (fcnt_p1 >= CW'(MAX_PEAK)) begin
                        state_d = ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (fcnt_p1 >= CW'(COOLDOWN)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_d != state_q) begin
                fcnt_d = '0;
            end else if (fcnt_q != FCNT_MAX) begin
                fcnt_d = fcnt_q + FCNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            light_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            light_q <= light_d;
            event_q <= event_d;
        end
    end

    assign light       = light_q;
    assign event_valid = event_q;

endmodule

// File: tb/tb_detect_clap.sv
// Self-checking bench for detect_clap: reference model feeds a scoreboard queue,
// each scenario task pops and compares outputs after every clock.
module tb_detect_clap;
    import clap_pkg::*;

    localparam int EW       = 16;
    localparam int TH_HIGH  = 1000;
    localparam int TH_LOW   = 500;
    localparam int MIN_GAP  = 2;
    localparam int MAX_GAP  = 20;
    localparam int MAX_PEAK = 4;
    localparam int COOLDOWN = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [EW-1:0] energy_data;
    logic          energy_valid;
    logic          energy_ready;
    logic          light;
    logic          event_valid;
    logic          event_ready;

    always #5 clock = ~clock;

    detect_clap #(
        .ENERGY_WIDTH (EW),
        .TH_HIGH      (TH_HIGH),
        .TH_LOW       (TH_LOW),
        .MIN_GAP      (MIN_GAP),
        .MAX_GAP      (MAX_GAP),
        .MAX_PEAK     (MAX_PEAK),
        .COOLDOWN     (COOLDOWN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .energy_data  (energy_data),
        .energy_valid (energy_valid),
        .energy_ready (energy_ready),
        .light        (light),
        .event_valid  (event_valid),
        .event_ready  (event_ready)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       light;
        logic       ev;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    exp_t want;
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_state;
    int m_fcnt;
    int m_floor;
    bit m_light;
    bit m_ev;

    // Drive one cycle from the falling edge, step the model, queue the expectation
    task automatic drive_cycle(input bit rst, input bit vld, input int data, input bit evr);
        bit acc;
        bit hi;
        bit lo;
        int th_h;
        int th_l;
        int ns;
        int emax;
        exp_t e;
        emax = (1 << EW) - 1;
        reset        = rst;
        energy_valid = vld;
        energy_data  = EW'(data);
        event_ready  = evr;
        acc = vld && !m_ev;
        if (rst) begin
            m_state = 0; m_fcnt = 0; m_light = 0; m_ev = 0; m_floor = 0;
        end else begin
            if (m_ev && evr) m_ev = 0;
            if (acc) begin
                th_h = TH_HIGH + m_floor;
                th_l = TH_LOW + m_floor;
                if (th_h > emax) th_h = emax;
                if (th_l > emax) th_l = emax;
                hi = data >= th_h;
                lo = data < th_l;
                ns = m_state;
                case (m_state)
                    0: if (hi) ns = 1;
                    1: if (lo) ns = 2; else if (m_fcnt + 1 >= MAX_PEAK) ns = 4;
                    2: if (hi) ns = (m_fcnt >= MIN_GAP) ? 3 : 4;
                       else if (m_fcnt + 1 >= MAX_GAP) ns = 0;
                    3: if (lo) begin ns = 4; m_light = !m_light; m_ev = 1; end
                       else if (m_fcnt + 1 >= MAX_PEAK) ns = 4;
                    default: if (m_fcnt + 1 >= COOLDOWN) ns = 0;
                endcase
`ifdef DETECT_CLAP_NOISE_FLOOR_EN
                if (m_state == 0 && !hi) m_floor = m_floor - (m_floor >> 4) + (data >> 4);
`endif
                if (ns != m_state) m_fcnt = 0;
                else if (m_fcnt < 65535) m_fcnt = m_fcnt + 1;
                m_state = ns;
            end
        end
        e.st    = 3'(m_state);
        e.light = m_light;
        e.ev    = m_ev;
        e.rdy   = !m_ev;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1, 1, 2000, 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, got, want);
            end
        end
        n_cmp++;
        if ({light, event_valid, energy_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 001", {light, event_valid, energy_ready});
        end
    endtask

    task automatic test_double_clap();
        int fr[$] = '{100, 1200, 1200, 300, 300, 300, 1500, 200};
        drive_cycle(1, 0, 0, 1);
        void'(sb.pop_front());
        foreach (fr[i]) begin
            drive_cycle(0, 1, fr[i], 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL double_clap frame %0d: got %b expected %b", i, got, want);
            end
        end
        n_cmp++;
        if (light !== 1'b1 || event_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL double_clap_toggle: light=%b ev=%b expected 1 1", light, event_valid);
        end
        drive_cycle(0, 1, 100, 1);
        void'(sb.pop_front());
        n_cmp++;
        if (event_valid !== 1'b0 || light !== 1'b1) begin
            n_bad++;
            $display("FAIL double_clap_event_width: ev=%b light=%b expected 0 1", event_valid, light);
        end
    endtask

    task automatic test_short_gap();
        int fr[$] = '{1200, 300, 1500, 200};
        drive_cycle(1, 0, 0, 1);
        void'(sb.pop_front());
        foreach (fr[i]) begin
            drive_cycle(0, 1, fr[i], 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL short_gap frame %0d: got %b expected %b", i, got, want);
            end
        end
        n_cmp++;
        if ({3'(dut.state_q), light, event_valid} !== {3'(ST_COOL), 2'b00}) begin
            n_bad++;
            $display("FAIL short_gap_cool: state=%0d light=%b ev=%b expected 4 0 0",
                     dut.state_q, light, event_valid);
        end
    endtask

    task automatic test_gap_timeout();
        drive_cycle(1, 0, 0, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 23; i++) begin
            drive_cycle(0, 1, (i == 0) ? 1200 : ((i == 22) ? 1500 : 100), 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL gap_timeout frame %0d: got %b expected %b", i, got, want);
            end
            if (i == 21) begin
                n_cmp++;
                if (3'(dut.state_q) !== 3'(ST_IDLE)) begin
                    n_bad++;
                    $display("FAIL gap_timeout_idle: state=%0d expected 0", dut.state_q);
                end
            end
        end
        n_cmp++;
        if (3'(dut.state_q) !== 3'(ST_PEAK1)) begin
            n_bad++;
            $display("FAIL gap_timeout_peak1: state=%0d expected 1", dut.state_q);
        end
    endtask

    task automatic test_backpressure();
        int fr[$] = '{1200, 300, 300, 300, 1500, 200};
        drive_cycle(1, 0, 0, 0);
        void'(sb.pop_front());
        foreach (fr[i]) begin
            drive_cycle(0, 1, fr[i], 0);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL backpressure frame %0d: got %b expected %b", i, got, want);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 1500, 0);
            void'(sb.pop_front());
            n_cmp++;
            if (event_valid !== 1'b1 || energy_ready !== 1'b0 || 3'(dut.state_q) !== 3'(ST_COOL)) begin
                n_bad++;
                $display("FAIL backpressure_hold %0d: ev=%b rdy=%b state=%0d expected 1 0 4",
                         i, event_valid, energy_ready, dut.state_q);
            end
        end
        drive_cycle(0, 1, 1500, 1);
        void'(sb.pop_front());
        n_cmp++;
        if (event_valid !== 1'b0 || energy_ready !== 1'b1 || light !== 1'b1) begin
            n_bad++;
            $display("FAIL backpressure_release: ev=%b rdy=%b light=%b expected 0 1 1",
                     event_valid, energy_ready, light);
        end
    endtask

    task automatic test_sustained_noise();
        drive_cycle(1, 0, 0, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 14; i++) begin
            drive_cycle(0, 1, (i < 4) ? 1200 : ((i < 13) ? 2000 : 200), 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL sustained frame %0d: got %b expected %b", i, got, want);
            end
        end
        n_cmp++;
        if (light !== 1'b0 || event_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sustained_no_event: light=%b ev=%b expected 0 0", light, event_valid);
        end
    endtask

    task automatic test_reset_mid_peak2();
        int fr[$] = '{1200, 300, 300, 300, 1500, 200, 100, 100, 100, 100, 100, 100, 100, 100, 100,
                      1200, 300, 300, 300, 1500};
        drive_cycle(1, 0, 0, 1);
        void'(sb.pop_front());
        foreach (fr[i]) begin
            drive_cycle(0, 1, fr[i], 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL mid_peak2 frame %0d: got %b expected %b", i, got, want);
            end
        end
        n_cmp++;
        if (3'(dut.state_q) !== 3'(ST_PEAK2) || light !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_peak2_setup: state=%0d light=%b expected 3 1", dut.state_q, light);
        end
        drive_cycle(1, 1, 200, 0);
        void'(sb.pop_front());
        n_cmp++;
        if ({3'(dut.state_q), light, event_valid, energy_ready} !== {3'(ST_IDLE), 3'b001}) begin
            n_bad++;
            $display("FAIL mid_peak2_reset: state=%0d light=%b ev=%b rdy=%b expected 0 0 0 1",
                     dut.state_q, light, event_valid, energy_ready);
        end
    endtask

    task automatic test_reset_pending_event();
        int fr[$] = '{1200, 300, 300, 300, 1500, 200};
        drive_cycle(1, 0, 0, 0);
        void'(sb.pop_front());
        foreach (fr[i]) begin
            drive_cycle(0, 1, fr[i], 0);
            void'(sb.pop_front());
        end
        drive_cycle(1, 1, 1500, 0);
        want = sb.pop_front();
        got  = {3'(dut.state_q), light, event_valid, energy_ready};
        n_cmp++;
        if (got !== want || event_valid !== 1'b0 || light !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pending: got %b expected %b", got, want);
        end
    endtask

    task automatic test_random();
        int vals[5] = '{100, 300, 600, 1200, 2000};
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                        vals[$urandom_range(0, 4)], $urandom_range(0, 2) != 0);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b expected %b", i, got, want);
            end
        end
    endtask

`ifdef DETECT_CLAP_NOISE_FLOOR_EN
    task automatic test_noise_floor();
        drive_cycle(1, 0, 0, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 17; i++) begin
            drive_cycle(0, 1, (i < 16) ? 800 : 1200, 1);
            want = sb.pop_front();
            got  = {3'(dut.state_q), light, event_valid, energy_ready};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL noise_floor frame %0d: got %b expected %b", i, got, want);
            end
        end
        n_cmp++;
        if (dut.u_floor.floor_q == '0 || 3'(dut.state_q) !== 3'(ST_IDLE)) begin
            n_bad++;
            $display("FAIL noise_floor_raise: floor=%0d state=%0d expected nonzero 0",
                     dut.u_floor.floor_q, dut.state_q);
        end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        energy_valid = 1'b0;
        energy_data  = '0;
        event_ready  = 1'b0;
        m_state = 0; m_fcnt = 0; m_floor = 0; m_light = 0; m_ev = 0;
        @(negedge clock);
        test_reset();
        test_double_clap();
        test_short_gap();
        test_gap_timeout();
        test_backpressure();
        test_sustained_noise();
        test_reset_mid_peak2();
        test_reset_pending_event();
`ifdef DETECT_CLAP_NOISE_FLOOR_EN
        test_noise_floor();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
